// File: rtl/line_burst_pkg.sv
// Shared types and sizes for the L2 line to memory burst adaptor.
// Beat 0 always occupies the least significant bits of a line.
package line_burst_pkg;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int BEATS   = LINE_W / BURST_W;

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } lba_state_t;

  typedef logic [1:0] beat_idx_t;

endpackage

// File: rtl/line_beat_buffer.sv
// Line register with beat-indexed access and a whole-line load.
// Serves write disassembly and read assembly alike.
module line_beat_buffer
  import line_burst_pkg::*;
#(
  parameter int LINE_W  = line_burst_pkg::LINE_W,
  parameter int BURST_W = line_burst_pkg::BURST_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [LINE_W-1:0]  line_in,
  input  logic               wr,
  input  beat_idx_t          idx,
  input  logic [BURST_W-1:0] beat_in,
  output logic [BURST_W-1:0] beat_out,
  output logic [LINE_W-1:0]  line
);

  logic [LINE_W-1:0] data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data <= '0;
    end else if (load) begin
      data <= line_in;
    end else if (wr) begin
      data[int'(idx)*BURST_W +: BURST_W] <= beat_in;
    end
  end

  assign beat_out = data[int'(idx)*BURST_W +: BURST_W];
  assign line     = data;

endmodule

// File: rtl/line_burst_adaptor.sv
// Turns one L2 line read/write into a 4-beat memory burst.
// line_o is a separate register so later writes cannot disturb it.
module line_burst_adaptor
  import line_burst_pkg::*;
#(
  parameter int LINE_W  = line_burst_pkg::LINE_W,
  parameter int BURST_W = line_burst_pkg::BURST_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  lba_state_t        state;
  beat_idx_t         cnt;
  logic [31:0]       addr;
  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] buf_line;
  logic              last;
  logic              buf_load;
  logic              buf_wr;

  assign last     = resp_i && (cnt == beat_idx_t'(BEATS - 1));
  assign buf_load = (state == IDLE) && write_i;
  assign buf_wr   = (state == RD_BURST) && resp_i;

  line_beat_buffer #(
    .LINE_W  (LINE_W),
    .BURST_W (BURST_W)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (buf_load),
    .line_in  (line_i),
    .wr       (buf_wr),
    .idx      (cnt),
    .beat_in  (burst_i),
    .beat_out (burst_o),
    .line     (buf_line)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      addr   <= '0;
      line_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (write_i) begin
            addr  <= address_i & ~32'h1f;
            state <= WR_BURST;
          end else if (read_i) begin
            addr  <= address_i & ~32'h1f;
            state <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (resp_i) begin
            cnt <= cnt + 2'd1;
          end
          // final beat lands straight in line_o alongside the buffered ones
          if (last) begin
            line_q <= {burst_i, buf_line[LINE_W-BURST_W-1:0]};
            state  <= DONE;
          end
        end
        WR_BURST: begin
          if (resp_i) begin
            cnt <= cnt + 2'd1;
          end
          if (last) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign read_o    = (state == RD_BURST);
  assign write_o   = (state == WR_BURST);
  assign resp_o    = (state == DONE);
  assign address_o = addr;
  assign line_o    = line_q;

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Scoreboard bench for line_burst_adaptor: expected beats/lines queued
// at request time and consumed as the DUT strobes or responds.
module tb_line_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] line_i = '0;
  logic [255:0] line_o;
  logic [31:0]  address_i = '0;
  logic         read_i = 1'b0;
  logic         write_i = 1'b0;
  logic         resp_o;
  logic [63:0]  burst_i = '0;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [63:0]  beat_q[$];
  logic [255:0] line_q[$];

  line_burst_adaptor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic run_xfer(input logic wr, input logic rd,
                          input logic [31:0] a, input logic [255:0] ln,
                          input logic [15:0] pat, input int plen,
                          input string nm);
    logic [31:0]  exp_addr;
    logic [255:0] exp_line;
    logic [63:0]  exp_beat;
    int           beats;
    int           i;
    logic         b;
    exp_addr = a & ~32'h1f;
    exp_line = '0;
    if (wr) begin
      for (int k = 0; k < 4; k++) beat_q.push_back(ln[k*64 +: 64]);
    end else begin
      line_q.push_back(ln);
    end
    @(negedge clk);
    read_i = rd; write_i = wr; address_i = a; line_i = ln;
    @(negedge clk);
    address_i = ~a; line_i = ~ln;
    beats = 0; i = 0;
    while (beats < 4 && i < 40) begin
      tests++;
      if (read_o !== !wr || write_o !== wr || resp_o !== 1'b0) begin
        fails++;
        $display("FAIL %s_ctl cyc%0d: rd=%b wr=%b resp=%b need rd=%b wr=%b resp=0",
                 nm, i, read_o, write_o, resp_o, !wr, wr);
      end
      tests++;
      if (address_o !== exp_addr) begin
        fails++;
        $display("FAIL %s_addr: got %h need %h", nm, address_o, exp_addr);
      end
      b = (i < plen) ? pat[i] : 1'b1;
      resp_i = b;
      burst_i = {$urandom, $urandom};
      if (b) begin
        if (wr) begin
          tests++;
          if (beat_q.size() == 0) begin
            fails++;
            $display("FAIL %s_beatq: empty at beat %0d", nm, beats);
          end else begin
            exp_beat = beat_q.pop_front();
            if (burst_o !== exp_beat) begin
              fails++;
              $display("FAIL %s_burst%0d: got %h need %h", nm, beats,
                       burst_o, exp_beat);
            end
          end
        end else begin
          burst_i = ln[beats*64 +: 64];
        end
        beats++;
      end
      @(negedge clk);
      i++;
    end
    resp_i = 1'b0;
    burst_i = {$urandom, $urandom};
    tests++;
    if (beats < 4) begin
      fails++;
      $display("FAIL %s_timeout: beats %0d need 4", nm, beats);
    end
    tests++;
    if (resp_o !== 1'b1 || read_o !== 1'b0 || write_o !== 1'b0) begin
      fails++;
      $display("FAIL %s_done: resp=%b rd=%b wr=%b need 1 0 0",
               nm, resp_o, read_o, write_o);
    end
    if (!wr) begin
      tests++;
      if (line_q.size() == 0) begin
        fails++;
        $display("FAIL %s_lineq: empty", nm);
      end else begin
        exp_line = line_q.pop_front();
        if (line_o !== exp_line) begin
          fails++;
          $display("FAIL %s_line: got %h need %h", nm, line_o, exp_line);
        end
      end
    end
    read_i = 1'b0; write_i = 1'b0;
    @(negedge clk);
    tests++;
    if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle: resp=%b rd=%b wr=%b need 0 0 0",
               nm, resp_o, read_o, write_o);
    end
    if (!wr) begin
      tests++;
      if (line_o !== exp_line) begin
        fails++;
        $display("FAIL %s_hold: got %h need %h", nm, line_o, exp_line);
      end
    end
    if (wr) begin
      tests++;
      if (beat_q.size() != 0) begin
        fails++;
        $display("FAIL %s_leftover: %0d beats need 0", nm, beat_q.size());
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; read_i = 1'b1; address_i = 32'hdead_beef;
    repeat (2) @(negedge clk);
    tests++;
    if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctl: rd=%b wr=%b resp=%b need 0 0 0",
               read_o, write_o, resp_o);
    end
    tests++;
    if (line_o !== '0 || burst_o !== '0 || address_o !== '0) begin
      fails++;
      $display("FAIL reset_data: line=%h burst=%h addr=%h need 0",
               line_o, burst_o, address_o);
    end
    read_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read();
    run_xfer(1'b0, 1'b1, 32'h0000_1234,
             {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}},
             16'hffff, 4, "read_b2b");
  endtask

  task automatic test_write_gaps();
    run_xfer(1'b1, 1'b0, 32'h00ab_cd5f,
             {64'hd3d3_0303_3333_d3d3, 64'hd2d2_0202_2222_d2d2,
              64'hd1d1_0101_1111_d1d1, 64'hd0d0_0000_0000_d0d0},
             16'h0059, 7, "write_gaps");
  endtask

  task automatic test_both();
    run_xfer(1'b1, 1'b1, 32'hffff_ffff,
             {64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210,
              64'hcafe_f00d_beef_0001, 64'h5a5a_a5a5_0f0f_f0f0},
             16'h0005, 4, "both");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    read_i = 1'b1; address_i = 32'h8000_0040;
    @(negedge clk);
    repeat (2) begin
      resp_i = 1'b1; burst_i = 64'hbad0_bad0_bad0_bad0;
      @(negedge clk);
    end
    resp_i = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if (read_o !== 1'b0 || resp_o !== 1'b0 || address_o !== '0) begin
      fails++;
      $display("FAIL midrst_state: rd=%b resp=%b addr=%h need 0 0 0",
               read_o, resp_o, address_o);
    end
    rst_n = 1'b1; read_i = 1'b0;
    @(negedge clk);
    tests++;
    if (read_o !== 1'b0 || resp_o !== 1'b0) begin
      fails++;
      $display("FAIL midrst_idle: rd=%b resp=%b need 0 0", read_o, resp_o);
    end
    run_xfer(1'b0, 1'b1, 32'h0040_0088,
             {64'h7777_0000_7777_0003, 64'h6666_0000_6666_0002,
              64'h5555_0000_5555_0001, 64'h4444_0000_4444_0000},
             16'h0006, 4, "after_rst");
  endtask

  task automatic test_spurious();
    repeat (3) begin
      resp_i = 1'b1; burst_i = 64'hffff_ffff_ffff_ffff;
      @(negedge clk);
      tests++;
      if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0) begin
        fails++;
        $display("FAIL spurious_idle: rd=%b wr=%b resp=%b need 0 0 0",
                 read_o, write_o, resp_o);
      end
    end
    resp_i = 1'b0;
    run_xfer(1'b0, 1'b1, 32'h1357_9bdf,
             {64'h0a0a_0a0a_0a0a_0a0a, 64'h0b0b_0b0b_0b0b_0b0b,
              64'h0c0c_0c0c_0c0c_0c0c, 64'h0d0d_0d0d_0d0d_0d0d},
             16'h000b, 5, "spurious");
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_gaps();
    test_both();
    test_reset_mid();
    test_spurious();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/line_burst_adaptor.md
# line_burst_adaptor

Responder for the L2 cache's physical-memory port. Accepts a whole-line read or write request (256-bit line, held-level handshake, single-cycle `resp`) from `l2_cache_control` and its datapath. Converts it into a 4-beat, 64-bit burst transaction toward main memory. Returns a one-cycle completion response to the L2 once the last beat is transferred.

## Interface
Parameters
- `LINE_W`, 256, cache line width in bits
- `BURST_W`, 64, beat width in bits; `LINE_W/BURST_W` = 4 beats

Ports
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `line_i`  in  256  write line from L2, sampled at request accept
- `line_o`  out  256  read line to L2, valid while `resp_o`=1, held until next read completes
- `address_i`  in  32  line address from L2
- `read_i`  in  1  L2 line read request, level, held until `resp_o`
- `write_i`  in  1  L2 line write request, level, held until `resp_o`
- `resp_o`  out  1  one-cycle completion pulse to L2
- `burst_i`  in  64  read beat from memory, valid when `resp_i`=1
- `burst_o`  out  64  write beat to memory
- `address_o`  out  32  line-aligned address to memory
- `read_o`  out  1  memory burst read request
- `write_o`  out  1  memory burst write request
- `resp_i`  in  1  memory beat strobe; one beat transferred per cycle high

## Operation
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - `write_i`=1 → latch `line_i`, latch `{address_i[31:5],5'b0}`, beat counter ← 0, go to WR_BURST.
  - Otherwise `read_i`=1 → latch the aligned address, go to RD_BURST.
  - Both asserted → write wins.
  - `resp_i` in IDLE or DONE is ignored.
- RD_BURST:
  - `read_o`=1.
  - On each `resp_i`=1: `burst_i` → line buffer bits [64k+63:64k] for counter value k, and the counter increments.
  - On the resp_i with k=3 → DONE.
- WR_BURST:
  - `write_o`=1; `burst_o` = latched line bits [64k+63:64k].
  - Counter increments on each `resp_i`; on k=3 → DONE.
- DONE:
  - `resp_o`=1 for exactly one cycle; next state IDLE.
  - Following a read, `line_o` exposes the assembled line.
- Counter: 2 bits, wraps 3→0 on the final beat; never incremented outside a burst state.
- `resp_i` may have gaps (non-consecutive beats); the state holds with outputs stable until the next strobe.
- Upstream contract: the L2 deasserts its request in the cycle after `resp_o`. The IDLE cycle after DONE therefore sees no stale request.
- `address_i` and `line_i` changes after accept have no effect on the current transaction.

## Timing
- Reset (`rst_n`=0 at a clock edge):
  - State ← IDLE, counter ← 0.
  - `read_o`=`write_o`=`resp_o`=0; `line_o`, `burst_o`, `address_o` ← 0.
  - Applies mid-burst as well; the partial transaction is abandoned and no `resp_o` is issued.
- `read_o`, `write_o`, `resp_o` are decoded from registered state only; no combinational path from any input.
- `burst_o` and `address_o` are registered or derived from registered state.
- Minimum latency: request sampled at cycle 0; `read_o`/`write_o` high in cycle 1; `resp_i` at cycles 1–4; `resp_o` at cycle 5.
- General latency: `resp_o` occurs 1 cycle after the 4th `resp_i`.
- `address_o` is stable for the whole burst; the low 5 bits are always 0.

## Structure
- Shared package `line_burst_pkg`:
  - `LINE_W`, `BURST_W`, `BEATS`(=4)
  - State enum `lba_state_t` {IDLE, RD_BURST, WR_BURST, DONE}
  - Beat-index type `beat_idx_t` (2-bit)
- One sub-module `line_beat_buffer`:
  - 256-bit register with beat-indexed 64-bit write and read and a full-line load.
  - Used for both read assembly and write disassembly.
- The FSM, counter and address register live in the top module.

## Test plan
- Reset: hold `rst_n`=0 two cycles with `read_i`=1 → all outputs 0, no `read_o`.
- Read, back-to-back beats:
  - Stimulus: `address_i`=0x0000_1234, `read_i`=1; `burst_i`=0x11..11, 0x22..22, 0x33..33, 0x44..44 on 4 consecutive `resp_i` cycles.
  - Response: `address_o`=0x0000_1220; `resp_o` 1 cycle after the 4th beat; `line_o`={0x44..44, 0x33..33, 0x22..22, 0x11..11} (beat 0 in the LSBs).
- Write with gaps:
  - Stimulus: `line_i`={D3,D2,D1,D0}, `write_i`=1; `resp_i` pattern 1,0,0,1,1,0,1.
  - Response: `burst_o` shows D0,D1,D2,D3 at each strobe; `write_o` is held through the gaps; a single `resp_o` pulse.
- Simultaneous `read_i`=`write_i`=1 → WR_BURST taken; `read_o` stays 0.
- Reset mid-read after 2 beats → IDLE next cycle, no `resp_o`. A following read of a new address completes correctly with a fresh beat 0.
- Spurious `resp_i` in IDLE → no state change; the subsequent read still requires 4 beats.
